mix_columns: RTL and testbench

- AES MixColumns transform on a 128-bit state, per FIPS-197.
- Sits in the AES round datapath between ShiftRows and AddRoundKey.
- Output is registered with one cycle of latency. A valid flag travels alongside the data.
- Optional compile-time support for InvMixColumns, used by the decrypt datapath.

---
 rtl/mix_columns.sv | 95 +++++++++
 tb/tb_mix_columns.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns.sv
// AES MixColumns on a 128-bit column-major state, one registered cycle.
// Ports: clk, rst_n (async, active low), in_valid, state_in[127:0],
//        inv (only with MIX_COLUMNS_INV_EN: 1 = InvMixColumns),
//        out_valid, state_out[127:0].
// Byte k of the state is bits [127-8k -: 8]; column c is bytes 4c..4c+3.
// Define MIX_COLUMNS_INV_EN to add the inv port and the inverse matrix.
module mix_columns (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [127:0] state_in,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    output logic [127:0] state_out
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward matrix rows: [2 3 1 1] rotated right per row.
    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Inverse matrix rows: [e b d 9] rotated right per row.
    // Each byte's 2x/4x/8x are shared by the four products that use it.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [7:0] b0, b1, b2, b3;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        b0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        b1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        b2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        b3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        return {b0, b1, b2, b3};
    endfunction
`endif

    logic [127:0] mixed;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
`ifdef MIX_COLUMNS_INV_EN
            mixed[127-32*c -: 32] = inv
                ? inv_col(state_in[127-32*c -: 32])
                : fwd_col(state_in[127-32*c -: 32]);
`else
            mixed[127-32*c -: 32] = fwd_col(state_in[127-32*c -: 32]);
`endif
        end
    end

    // state_in is only sampled under in_valid, so idle garbage never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state_out <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: matrix-level GF(2^8) model,
// literal FIPS-197 vectors, reset/hold cases and a random stream.
module tb_mix_columns;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] state_in;
    logic         inv;
    logic         out_valid;
    logic [127:0] state_out;

    int n_cmp;
    int n_bad;
    bit cmp_en;

    logic         m_valid;
    logic [127:0] m_state;

    mix_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .state_in  (state_in),
`ifdef MIX_COLUMNS_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [8:0] acc;
        logic [8:0] p;
        acc = '0;
        p   = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = p << 1;
            if (p[8]) p = p ^ 9'h11b;
        end
        return acc[7:0];
    endfunction

    // Circulant matrix product: M[r][j] = row0[(j - r) mod 4].
    function automatic logic [127:0] model_mix(input logic [127:0] s,
                                               input logic         use_inv);
        logic [7:0]   row0 [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (use_inv) begin
            row0[0] = 8'h0e; row0[1] = 8'h0b;
            row0[2] = 8'h0d; row0[3] = 8'h09;
        end else begin
            row0[0] = 8'h02; row0[1] = 8'h03;
            row0[2] = 8'h01; row0[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(row0[(j - rr + 4) % 4], a[j]);
                r[127-8*(4*c+rr) -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string nm,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour of the stage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_state = '0;
        end else begin
            m_valid = in_valid;
`ifdef MIX_COLUMNS_INV_EN
            if (in_valid) m_state = model_mix(state_in, inv);
`else
            if (in_valid) m_state = model_mix(state_in, 1'b0);
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_valid", {127'd0, out_valid}, {127'd0, m_valid});
            check("model_state", state_out, m_state);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [127:0] v_a, v_b, y;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        cmp_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        state_in = '0;
        inv      = 1'b0;
        #2;
        check("reset_state", state_out, 128'h0);
        check("reset_valid", {127'd0, out_valid}, 128'h0);

        check("model_pin_col",
              model_mix(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0),
              128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        check("model_pin_inv",
              model_mix(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1),
              128'hd4bf5d30e0b452aeb84111f11e2798e5);

        step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step();

        // Zero input
        in_valid = 1'b1;
        state_in = '0;
        step();
        check("zero_state", state_out, 128'h0);
        check("zero_valid", {127'd0, out_valid}, 128'h1);
        in_valid = 1'b0;
        state_in = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
        step();
        check("zero_idle_valid", {127'd0, out_valid}, 128'h0);
        check("zero_hold", state_out, 128'h0);

        // Column vectors
        in_valid = 1'b1;
        state_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        step();
        check("fips_cols", state_out,
              128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

        // Back-to-back round 1
        state_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        step();
        check("r1_first", state_out, 128'h046681e5e0cb199a48f8d37a2806264c);
        check("r1_first_v", {127'd0, out_valid}, 128'h1);
        state_in = 128'hd4d4d4d5_2d26314c_f20a225c_db135345;
        step();
        check("r1_second", state_out,
              128'hd5d5d7d6_4d7ebdf8_9fdc589d_8e4da1bc);
        check("r1_second_v", {127'd0, out_valid}, 128'h1);

        // Hold with invalid input
        in_valid = 1'b0;
        state_in = 128'h0123456789abcdef0123456789abcdef;
        step();
        check("hold_state", state_out,
              128'hd5d5d7d6_4d7ebdf8_9fdc589d_8e4da1bc);
        check("hold_valid", {127'd0, out_valid}, 128'h0);

        // Reset mid-stream, asynchronously
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state_out, 128'h0);
        check("async_rst_valid", {127'd0, out_valid}, 128'h0);
        @(posedge clk);
        #1;
        check("rst_held_valid", {127'd0, out_valid}, 128'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check("post_rst_valid", {127'd0, out_valid}, 128'h0);
        check("post_rst_state", state_out, 128'h0);

`ifdef MIX_COLUMNS_INV_EN
        in_valid = 1'b1;
        inv      = 1'b1;
        state_in = 128'h046681e5e0cb199a48f8d37a2806264c;
        step();
        check("inv_fips", state_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        for (int i = 0; i < 1000; i++) begin
            v_a      = {$urandom, $urandom, $urandom, $urandom};
            inv      = 1'b0;
            state_in = v_a;
            step();
            y        = state_out;
            inv      = 1'b1;
            state_in = y;
            step();
            check("inv_roundtrip", state_out, v_a);
        end
        inv = 1'b0;
`endif

        // Random stream, compared every cycle against the model
        for (int i = 0; i < 500; i++) begin
            v_b      = {$urandom, $urandom, $urandom, $urandom};
            in_valid = ($urandom_range(0, 3) != 0);
            state_in = v_b;
`ifdef MIX_COLUMNS_INV_EN
            inv      = $urandom_range(0, 1) == 1;
`endif
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
